fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader_pkg.sv | 24 ++
 rtl/fifo_reader_skid.sv | 80 ++++++++
 rtl/fifo_reader.sv | 70 +++++++
 tb/tb_fifo_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the fifo_reader block.
// Occupancy encoding doubles as the number of buffered words.
package fifo_reader_pkg;

    localparam int unsigned COUNT_W = 16;

    typedef enum logic [1:0] {
        S_ZERO = 2'd0,
        S_ONE  = 2'd1,
        S_TWO  = 2'd2
    } occ_e;

    function automatic logic [1:0] occ_level(occ_e occ);
        logic [1:0] level;
        level = 2'd0;
        case (occ)
            S_ONE:   level = 2'd1;
            S_TWO:   level = 2'd2;
            default: level = 2'd0;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer: head register feeds the consumer, tail absorbs
// one extra word while the consumer stalls.
module fifo_reader_skid
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output occ_e             occ_o
);

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (flush_i) begin
            occ_d = S_ZERO;
        end else begin
            unique case (occ_q)
                S_ZERO: begin
                    if (push_i) begin
                        head_d = data_i;
                        occ_d  = S_ONE;
                    end
                end
                S_ONE: begin
                    if (push_i && pop_i) begin
                        head_d = data_i;
                    end else if (push_i) begin
                        tail_d = data_i;
                        occ_d  = S_TWO;
                    end else if (pop_i) begin
                        occ_d = S_ZERO;
                    end
                end
                S_TWO: begin
                    if (pop_i) begin
                        head_d = tail_q;
                        if (push_i) begin
                            tail_d = data_i;
                        end else begin
                            occ_d = S_ONE;
                        end
                    end
                end
                default: occ_d = S_ZERO;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= S_ZERO;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign data_o = head_q;
    assign occ_o  = occ_q;

    // The read throttle upstream must never let a word arrive with nowhere to go.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(push_i && !pop_i && occ_q == S_TWO));

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from a FIFO RAM (one-cycle read latency) into a two-entry output buffer.
// Define FIFO_READER_COUNT_EN to add the drain_count output.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fifo_empty,
    output logic               fifo_rd,
    input  logic [WIDTH-1:0]   fifo_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef FIFO_READER_COUNT_EN
    output logic [COUNT_W-1:0] drain_count,
`endif
    output logic [WIDTH-1:0]   out_data
);

    occ_e       occ;
    logic       inflight_q;
    logic       pop;
    logic       capture;
    logic [1:0] committed;

    assign out_valid = (occ != S_ZERO);
    assign pop       = out_valid & out_ready;
    // Words already buffered plus the one still coming back from the RAM.
    assign committed = occ_level(occ) + {1'b0, inflight_q};
    assign fifo_rd   = ~reset & ~fifo_empty & ~flush & ((committed < 2'd2) | pop);
    assign capture   = inflight_q & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= fifo_rd;
        end
    end

    fifo_reader_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .push_i  (capture),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (fifo_data),
        .data_o  (out_data),
        .occ_o   (occ)
    );

`ifdef FIFO_READER_COUNT_EN
    logic [COUNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (pop) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign drain_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Randomised and directed bench for fifo_reader against a queue-based reference model.
module tb_fifo_reader;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         fifo_empty = 1'b1;
    logic         fifo_rd;
    logic [W-1:0] fifo_data = '0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
`ifdef FIFO_READER_COUNT_EN
    logic [15:0]  drain_count;
`endif

    fifo_reader #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fifo_empty  (fifo_empty),
        .fifo_rd     (fifo_rd),
        .fifo_data   (fifo_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
`ifdef FIFO_READER_COUNT_EN
        .drain_count (drain_count),
`endif
        .out_data    (out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] src[$];      // contents of the upstream FIFO
    logic [W-1:0] m_buf[$];    // words the consumer can see, oldest first
    bit           m_fly = 1'b0;
    logic [W-1:0] m_fly_word = '0;
    bit           rd_pend = 1'b0;
    logic [W-1:0] rd_word = '0;
    int unsigned  m_count = 0;
    logic [W-1:0] seen[$];     // words actually taken from the DUT
    bit           act_rd;
    bit           act_valid;
    logic [W-1:0] act_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic step(input bit f, input bit r);
        bit e_pop;
        bit e_rd;
        flush      = f;
        out_ready  = r;
        fifo_empty = (src.size() == 0);
        fifo_data  = rd_pend ? rd_word : W'($urandom);
        #1;
        e_pop = (m_buf.size() > 0) && r;
        e_rd  = !fifo_empty && !f && (((m_buf.size() + int'(m_fly)) < 2) || e_pop);
        act_rd    = fifo_rd;
        act_valid = out_valid;
        act_data  = out_data;
        check("fifo_rd", 32'(fifo_rd), 32'(e_rd));
        check("out_valid", 32'(out_valid), 32'(m_buf.size() > 0));
        if (m_buf.size() > 0) check("out_data", 32'(out_data), 32'(m_buf[0]));
`ifdef FIFO_READER_COUNT_EN
        check("drain_count", 32'(drain_count), 32'(m_count[15:0]));
`endif
        if (out_valid && r) seen.push_back(out_data);
        if (e_pop) begin
            void'(m_buf.pop_front());
            m_count++;
        end
        if (f) m_buf.delete();
        else if (m_fly) m_buf.push_back(m_fly_word);
        m_fly   = e_rd;
        rd_pend = e_rd;
        if (e_rd) begin
            m_fly_word = src.pop_front();
            rd_word    = m_fly_word;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_fifo_rd", 32'(fifo_rd), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
`ifdef FIFO_READER_COUNT_EN
        check("rst_drain_count", 32'(drain_count), 32'h0);
`endif
        m_buf.delete();
        m_fly   = 1'b0;
        rd_pend = 1'b0;
        m_count = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bit           any;
        int           rds;
        bit           exp_rd[6];
        bit           exp_v[6];
        logic [W-1:0] exp_d[6];

        #1;
        do_reset();

        // Idle with an empty FIFO.
        any = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1);
            any = any | act_rd | act_valid;
        end
        check("idle_quiet", 32'(any), 32'h0);

        // Three preloaded words stream out back to back.
        do_reset();
        src.push_back(8'hA1); src.push_back(8'hA2); src.push_back(8'hA3);
        exp_rd = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_v  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_d  = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            check("stream_rd", 32'(act_rd), 32'(exp_rd[i]));
            check("stream_valid", 32'(act_valid), 32'(exp_v[i]));
            if (exp_v[i]) check("stream_data", 32'(act_data), 32'(exp_d[i]));
        end

        // Stalled consumer: only two reads issued, head held, then all four in order.
        do_reset();
        src.push_back(8'hB1); src.push_back(8'hB2); src.push_back(8'hB3); src.push_back(8'hB4);
        rds = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0);
            rds += int'(act_rd);
        end
        check("stall_rd_count", 32'(rds), 32'd2);
        check("stall_head", 32'(act_data), 32'hB1);
        check("stall_valid", 32'(act_valid), 32'h1);
        seen.delete();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
        check("stall_drain_n", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            check("stall_drain0", 32'(seen[0]), 32'hB1);
            check("stall_drain1", 32'(seen[1]), 32'hB2);
            check("stall_drain2", 32'(seen[2]), 32'hB3);
            check("stall_drain3", 32'(seen[3]), 32'hB4);
        end

        // Flush while a word is in flight: it must never appear.
        do_reset();
        src.push_back(8'hC1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        src.push_back(8'hC2);
        step(1'b0, 1'b0);
        check("flush_pre_rd", 32'(act_rd), 32'h1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("flush_valid", 32'(act_valid), 32'h0);
        src.push_back(8'hC3);
        seen.delete();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        check("flush_resume_n", 32'(seen.size()), 32'd1);
        if (seen.size() == 1) check("flush_resume", 32'(seen[0]), 32'hC3);

        // Asynchronous reset between edges with the buffer full.
        do_reset();
        src.push_back(8'hD1); src.push_back(8'hD2); src.push_back(8'hD3);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("full_valid", 32'(act_valid), 32'h1);
        #2;
        do_reset();
        src.delete();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(1, 0) == 1 && src.size() < 8) src.push_back(W'($urandom));
            step($urandom_range(15, 0) == 0, $urandom_range(3, 0) != 0);
        end

`ifdef FIFO_READER_COUNT_EN
        // Counter wraps past 0xFFFF and ignores flush.
        do_reset();
        for (int i = 0; i < 70000 && m_count < 65537; i++) begin
            if (src.size() < 4) src.push_back(W'($urandom));
            step(1'b0, 1'b1);
        end
        check("count_wrap", 32'(drain_count), 32'h1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        check("count_after_flush", 32'(drain_count), 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
